// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg: shared width, opcode and add/sub encodings for the Booth datapath.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package booth_pkg;

   localparam int BOOTH_N = 8;

   localparam logic BOOTH_SUB = 1'b1;
   localparam logic BOOTH_ADD = 1'b0;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_LOAD  = 3'd1,
      OP_ADD   = 3'd2,
      OP_SUB   = 3'd3,
      OP_SHIFT = 3'd4
   } booth_op_e;

   // Counter must hold the value N itself, hence N+1 states.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/booth_iter_counter.sv
// ----------------------------------------------------------------------------
// booth_iter_counter: shift-iteration counter with zero, last-shift and underflow.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module booth_iter_counter
   import booth_pkg::*;
#(
   parameter int N = BOOTH_N
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero,
   output logic last,
   output logic underflow
);

   localparam int CW = cnt_width(N);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(N);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero      = (cnt == '0);
   assign last      = dec && (cnt == CW'(1));
   assign underflow = dec && zero;

endmodule

`default_nettype wire

// File: rtl/booth_datapath.sv
// ----------------------------------------------------------------------------
// booth_datapath: M / HQ / LQ / Q_1 registers of a radix-2 Booth multiplier.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module booth_datapath
   import booth_pkg::*;
#(
   parameter int N = BOOTH_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_A,
   input  logic           load_B,
   input  logic           load_add,
   input  logic           add_sub,
   input  logic           shift_HQ_LQ_Q_1,
   input  logic [N-1:0]   A_in,
   input  logic [N-1:0]   B_in,
   output logic           Q_0,
   output logic           Q_1,
   output logic           Z,
   output logic [2*N-1:0] product,
   output logic           product_valid,
   output logic           err
);

   logic [N:0]   m_reg;
   logic [N:0]   hq_reg;
   logic [N-1:0] lq_reg;
   logic         q1_reg;
   logic         valid_reg;
   logic         err_reg;

   booth_op_e    op;
   logic [1:0]   n_classes;
   logic         multi_class;
   logic [N:0]   hq_sum;
   logic         cnt_zero;
   logic         cnt_last;
   logic         cnt_underflow;
   logic         err_set;

   always_comb begin
      op = OP_NONE;
      if (load_A || load_B) begin
         op = OP_LOAD;
      end else if (load_add) begin
         op = (add_sub == BOOTH_SUB) ? OP_SUB : OP_ADD;
      end else if (shift_HQ_LQ_Q_1) begin
         op = OP_SHIFT;
      end
   end

   assign n_classes   = {1'b0, load_A | load_B} + {1'b0, load_add} + {1'b0, shift_HQ_LQ_Q_1};
   assign multi_class = (n_classes > 2'd1);
   assign hq_sum      = (op == OP_SUB) ? (hq_reg - m_reg) : (hq_reg + m_reg);

   booth_iter_counter #(.N(N)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .load      ((op == OP_LOAD) && load_B),
      .dec       (op == OP_SHIFT),
      .zero      (cnt_zero),
      .last      (cnt_last),
      .underflow (cnt_underflow)
   );

   // Adds after the final shift are dropped so the product stays frozen.
   assign err_set = multi_class || cnt_underflow ||
                    (((op == OP_ADD) || (op == OP_SUB)) && cnt_zero);

   always_ff @(posedge clk) begin
      if (rst) begin
         m_reg     <= '0;
         hq_reg    <= '0;
         lq_reg    <= '0;
         q1_reg    <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         case (op)
            OP_LOAD: begin
               if (load_A) begin
                  m_reg <= {A_in[N-1], A_in};
               end
               if (load_B) begin
                  lq_reg    <= B_in;
                  hq_reg    <= '0;
                  q1_reg    <= 1'b0;
                  valid_reg <= 1'b0;
               end
            end
            OP_ADD, OP_SUB: begin
               if (!cnt_zero) begin
                  hq_reg <= hq_sum;
               end
            end
            OP_SHIFT: begin
               if (!cnt_zero) begin
                  q1_reg <= lq_reg[0];
                  lq_reg <= {hq_reg[0], lq_reg[N-1:1]};
                  hq_reg <= {hq_reg[N], hq_reg[N:1]};
                  if (cnt_last) begin
                     valid_reg <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (err_set) begin
         err_reg <= 1'b1;
      end
   end

   assign Q_0           = lq_reg[0];
   assign Q_1           = q1_reg;
   assign Z             = cnt_zero;
   assign product       = {hq_reg[N-1:0], lq_reg};
   assign product_valid = valid_reg;
   assign err           = err_reg;

endmodule

`default_nettype wire

// File: tb/tb_booth_datapath.sv
// ----------------------------------------------------------------------------
// tb_booth_datapath: acts as the Booth controller and compares against A*B.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_booth_datapath;
   import booth_pkg::*;

   localparam int N = BOOTH_N;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           load_A = 1'b0;
   logic           load_B = 1'b0;
   logic           load_add = 1'b0;
   logic           add_sub = 1'b0;
   logic           shift_HQ_LQ_Q_1 = 1'b0;
   logic [N-1:0]   A_in = '0;
   logic [N-1:0]   B_in = '0;
   logic           Q_0;
   logic           Q_1;
   logic           Z;
   logic [2*N-1:0] product;
   logic           product_valid;
   logic           err;

   int checks = 0;
   int passed = 0;

   booth_datapath #(.N(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .load_A          (load_A),
      .load_B          (load_B),
      .load_add        (load_add),
      .add_sub         (add_sub),
      .shift_HQ_LQ_Q_1 (shift_HQ_LQ_Q_1),
      .A_in            (A_in),
      .B_in            (B_in),
      .Q_0             (Q_0),
      .Q_1             (Q_1),
      .Z               (Z),
      .product         (product),
      .product_valid   (product_valid),
      .err             (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock with the given strobes; outputs are sampled 1 ns after the edge.
   task automatic drive(input logic r, input logic la, input logic lb,
                        input logic ld, input logic as_, input logic sh);
      rst = r; load_A = la; load_B = lb; load_add = ld; add_sub = as_; shift_HQ_LQ_Q_1 = sh;
      @(posedge clk);
      #1;
      rst = 0; load_A = 0; load_B = 0; load_add = 0; add_sub = 0; shift_HQ_LQ_Q_1 = 0;
   endtask

   task automatic start(input logic [N-1:0] a, input logic [N-1:0] b);
      A_in = a;
      B_in = b;
      drive(0, 1, 1, 0, 0, 0);
      check("load_q0", 32'(Q_0), 32'(b[0]));
      check("load_q1", 32'(Q_1), 32'd0);
      check("load_z", 32'(Z), 32'd0);
      check("load_valid", 32'(product_valid), 32'd0);
   endtask

   // Booth recoding straight from the multiplier bits: (b[i], b[i-1]).
   task automatic iterate(input logic [N-1:0] b, input int from, input int upto);
      logic prev;
      for (int i = from; i < upto; i++) begin
         prev = 1'b0;
         if (i > 0) prev = b[i-1];
         if ({b[i], prev} == 2'b10) drive(0, 0, 0, 1, BOOTH_SUB, 0);
         else if ({b[i], prev} == 2'b01) drive(0, 0, 0, 1, BOOTH_ADD, 0);
         drive(0, 0, 0, 0, 0, 1);
         check("iter_q1", 32'(Q_1), 32'(b[i]));
         check("iter_z", 32'(Z), 32'(i + 1 == N));
         check("iter_valid", 32'(product_valid), 32'(i + 1 == N));
         if (i + 1 < N) check("iter_q0", 32'(Q_0), 32'(b[i+1]));
      end
   endtask

   function automatic logic [2*N-1:0] ref_product(input logic [N-1:0] a, input logic [N-1:0] b);
      int sa;
      int sb;
      int p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[2*N-1:0];
   endfunction

   task automatic mult(input logic [N-1:0] a, input logic [N-1:0] b, input logic exp_err);
      logic [2*N-1:0] e;
      e = ref_product(a, b);
      start(a, b);
      iterate(b, 0, N);
      check("product", 32'(product), 32'(e));
      check("final_q0", 32'(Q_0), 32'(e[0]));
      check("final_valid", 32'(product_valid), 32'd1);
      check("final_z", 32'(Z), 32'd1);
      check("final_err", 32'(err), 32'(exp_err));
   endtask

   initial begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;

      drive(1, 0, 0, 0, 0, 0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_valid", 32'(product_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_q0", 32'(Q_0), 32'd0);
      check("rst_q1", 32'(Q_1), 32'd0);
      check("rst_z", 32'(Z), 32'd1);

      mult(8'd3, 8'd5, 0);
      check("dir_3x5", 32'(product), 32'h000F);
      mult(-8'sd3, 8'd7, 0);
      check("dir_m3x7", 32'(product), 32'hFFEB);
      mult(8'd7, -8'sd3, 0);
      check("dir_7xm3", 32'(product), 32'hFFEB);
      mult(8'h80, 8'h80, 0);
      check("dir_m128sq", 32'(product), 32'h4000);
      mult(8'h80, 8'h7F, 0);
      check("dir_m128x127", 32'(product), 32'hC080);
      mult(8'h55, 8'h00, 0);
      check("dir_55x0", 32'(product), 32'h0000);

      for (int k = 0; k < 20; k++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         mult(ra, rb, 0);
      end

      // Abort on the fourth shift: reset wins over the strobe.
      start(8'd9, 8'd9);
      iterate(8'd9, 0, 3);
      drive(1, 0, 0, 0, 0, 1);
      check("abort_product", 32'(product), 32'd0);
      check("abort_z", 32'(Z), 32'd1);
      check("abort_valid", 32'(product_valid), 32'd0);
      check("abort_q0", 32'(Q_0), 32'd0);
      check("abort_q1", 32'(Q_1), 32'd0);
      mult(8'd9, 8'd9, 0);
      check("dir_9x9", 32'(product), 32'h0051);

      mult(8'd3, 8'd5, 0);
      drive(0, 0, 0, 0, 0, 1);
      check("extra_shift_err", 32'(err), 32'd1);
      check("extra_shift_product", 32'(product), 32'h000F);
      check("extra_shift_z", 32'(Z), 32'd1);
      check("extra_shift_valid", 32'(product_valid), 32'd1);
      drive(1, 0, 0, 0, 0, 0);
      check("err_clear", 32'(err), 32'd0);

      // First Booth step (pair 10) issued with add and shift merged: only the subtract happens.
      start(8'd3, 8'd5);
      drive(0, 0, 0, 1, BOOTH_SUB, 1);
      check("merge_err", 32'(err), 32'd1);
      check("merge_z", 32'(Z), 32'd0);
      check("merge_q0", 32'(Q_0), 32'd1);
      check("merge_q1", 32'(Q_1), 32'd0);
      drive(0, 0, 0, 0, 0, 1);
      iterate(8'd5, 1, N);
      check("merge_product", 32'(product), 32'h000F);
      drive(0, 0, 0, 0, 0, 0);
      check("err_sticky", 32'(err), 32'd1);
      drive(1, 0, 0, 0, 0, 0);
      check("err_rst", 32'(err), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
